// File: rtl/des_mode_ctrl_if.sv
// Data-side stream bundle for the block-cipher mode controller:
// message setup, input block handshake and result block handshake.
interface des_mode_ctrl_if #(
    parameter int BLK_W = 64
);
    logic             enc_dec;
    logic             cbc;
    logic [BLK_W-1:0] iv;
    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic             in_first;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_data;

    modport master (
        output enc_dec, cbc, iv,
        output in_valid, in_data, in_first,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  enc_dec, cbc, iv,
        input  in_valid, in_data, in_first,
        output in_ready,
        input  out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/des_mode_ctrl.sv
// ECB/CBC chaining controller wrapped around an iterative block core
// driven by a start/done handshake; streams blocks with valid/ready.
module des_mode_ctrl #(
    parameter int BLK_W   = 64,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    des_mode_ctrl_if.slave   s,
    output logic             core_start,
    output logic             core_enc,
    output logic [BLK_W-1:0] core_din,
    input  logic [BLK_W-1:0] core_dout,
    input  logic             core_done,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [TW-1:0]    timer;
    logic             mode_enc;
    logic             mode_cbc;
    logic [BLK_W-1:0] chain;
    logic [BLK_W-1:0] ct_hold;
    logic [BLK_W-1:0] out_q;

    logic             accept;
    logic             capture;
    logic             xfer;
    logic             eff_enc;
    logic             eff_cbc;
    logic [BLK_W-1:0] eff_chain;

    assign s.out_data = out_q;
    assign core_enc   = mode_enc;

    // A first block uses its own mode/iv even though the regs load at the same edge
    assign eff_enc   = s.in_first ? s.enc_dec : mode_enc;
    assign eff_cbc   = s.in_first ? s.cbc : mode_cbc;
    assign eff_chain = s.in_first ? s.iv : chain;

    always_comb begin
        state_nx    = state;
        s.in_ready  = 1'b0;
        s.out_valid = 1'b0;
        core_start  = 1'b0;
        err         = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        xfer        = 1'b0;
        unique case (state)
            IDLE: begin
                s.in_ready = 1'b1;
                if (s.in_valid) begin
                    accept   = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                core_start = 1'b1;
                state_nx   = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    capture  = 1'b1;
                    state_nx = OUT;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    err      = 1'b1;
                    state_nx = IDLE;
                end
            end
            OUT: begin
                s.out_valid = 1'b1;
                if (s.out_ready) begin
                    xfer     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            timer    <= '0;
            mode_enc <= 1'b1;
            mode_cbc <= 1'b0;
            chain    <= '0;
            ct_hold  <= '0;
            out_q    <= '0;
            core_din <= '0;
            blk_cnt  <= '0;
        end else begin
            state <= state_nx;

            if (state == START) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + TW'(1);
            end

            if (accept) begin
                if (s.in_first) begin
                    mode_enc <= s.enc_dec;
                    mode_cbc <= s.cbc;
                    chain    <= s.iv;
                    blk_cnt  <= '0;
                end
                if (eff_enc && eff_cbc) begin
                    core_din <= s.in_data ^ eff_chain;
                end else begin
                    core_din <= s.in_data;
                end
                if (!eff_enc && eff_cbc) begin
                    ct_hold <= s.in_data;
                end
            end

            if (capture) begin
                if (mode_cbc && mode_enc) begin
                    out_q <= core_dout;
                    chain <= core_dout;
                end else if (mode_cbc) begin
                    out_q <= core_dout ^ chain;
                    chain <= ct_hold;
                end else begin
                    out_q <= core_dout;
                end
            end

            if (xfer && (blk_cnt != {CNT_W{1'b1}})) begin
                blk_cnt <= blk_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_des_mode_ctrl.sv
// Self-checking bench: directed vector table, corner sequences and
// randomized blocks compared against a mode-level reference model.
module tb_des_mode_ctrl;

    localparam int W   = 64;
    localparam int CW  = 4;
    localparam int TO  = 32;
    localparam int DLY = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    des_mode_ctrl_if #(.BLK_W(W)) bus ();

    logic          core_start;
    logic          core_enc;
    logic [W-1:0]  core_din;
    logic [W-1:0]  core_dout = '0;
    logic          core_done = 1'b0;
    logic [CW-1:0] blk_cnt;
    logic          err;

    des_mode_ctrl #(
        .BLK_W  (W),
        .CNT_W  (CW),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus.slave),
        .core_start(core_start),
        .core_enc  (core_enc),
        .core_din  (core_din),
        .core_dout (core_dout),
        .core_done (core_done),
        .blk_cnt   (blk_cnt),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Core stand-in: inverts its input, done a fixed delay after start
    int core_delay = DLY;
    bit core_en    = 1'b1;
    bit pend       = 1'b0;
    int rem        = 0;

    always @(posedge clk) begin
        #2;
        core_done = 1'b0;
        if (pend) begin
            rem--;
            if (rem == 0) begin
                core_done = 1'b1;
                core_dout = core_din ^ {W{1'b1}};
                pend      = 1'b0;
            end
        end
        if (core_start && core_en) begin
            pend = 1'b1;
            rem  = core_delay;
        end
    end

    // Mode-level reference model
    bit           m_enc   = 1'b1;
    bit           m_cbc   = 1'b0;
    logic [W-1:0] m_chain = '0;
    int           m_cnt   = 0;

    task automatic model_reset();
        m_enc   = 1'b1;
        m_cbc   = 1'b0;
        m_chain = '0;
        m_cnt   = 0;
    endtask

    task automatic model(input bit first, input bit enc, input bit cbc,
                         input logic [W-1:0] ivv, input logic [W-1:0] data,
                         output logic [W-1:0] din,
                         output logic [W-1:0] res);
        if (first) begin
            m_enc   = enc;
            m_cbc   = cbc;
            m_chain = ivv;
            m_cnt   = 0;
        end
        if (m_cbc && m_enc) begin
            din     = data ^ m_chain;
            res     = ~din;
            m_chain = res;
        end else if (m_cbc) begin
            din     = data;
            res     = ~data ^ m_chain;
            m_chain = data;
        end else begin
            din = data;
            res = ~data;
        end
        if (m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic drive_in(input bit first, input bit enc, input bit cbc,
                            input logic [W-1:0] ivv,
                            input logic [W-1:0] data);
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.enc_dec  = enc;
        bus.cbc      = cbc;
        bus.iv       = ivv;
        bus.in_data  = data;
    endtask

    task automatic run_block(input bit first, input bit enc, input bit cbc,
                             input logic [W-1:0] ivv,
                             input logic [W-1:0] data,
                             input logic [W-1:0] exp_din,
                             input logic [W-1:0] exp_out,
                             input bit exp_enc, input int exp_cnt,
                             input int rdly, input int exp_lat,
                             input string tag);
        int           n;
        int           errs;
        logic [W-1:0] hold;
        errs = 0;
        @(negedge clk);
        chk({tag, ".rdy_idle"}, 64'(bus.in_ready), 64'd1);
        drive_in(first, enc, cbc, ivv, data);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        chk({tag, ".start"}, 64'(core_start), 64'd1);
        chk({tag, ".din"}, core_din, exp_din);
        chk({tag, ".enc"}, 64'(core_enc), 64'(exp_enc));
        while (!bus.out_valid && n < 80) begin
            @(negedge clk);
            n++;
            if (err) errs++;
        end
        chk({tag, ".lat"}, 64'(n), 64'(exp_lat));
        chk({tag, ".out"}, bus.out_data, exp_out);
        chk({tag, ".noerr"}, 64'(errs), 64'd0);
        hold = bus.out_data;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk({tag, ".bp_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, ".bp_data"}, bus.out_data, hold);
            chk({tag, ".bp_rdy"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".rdy_after"}, 64'(bus.in_ready), 64'd1);
        chk({tag, ".vld_after"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".cnt"}, 64'(blk_cnt), 64'(exp_cnt));
    endtask

    typedef struct {
        bit           first;
        bit           enc;
        bit           cbc;
        logic [W-1:0] iv;
        logic [W-1:0] data;
        logic [W-1:0] din;
        logic [W-1:0] res;
        int           cnt;
        int           rdly;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int           n;
        int           errs;
        int           seen;
        logic [W-1:0] ivv;
        logic [W-1:0] data;
        logic [W-1:0] edin;
        logic [W-1:0] eout;
        bit           first;
        bit           enc;
        bit           cbc;

        tbl[0] = '{1, 1, 0, 64'h0, 64'h0123456789ABCDEF,
                   64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1, 5};
        tbl[1] = '{1, 1, 1, 64'h00000000FFFFFFFF, 64'h0,
                   64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000, 1, 0};
        tbl[2] = '{0, 1, 1, 64'h0, 64'h0,
                   64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, 2, 1};
        tbl[3] = '{1, 0, 1, 64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000,
                   64'hFFFFFFFF00000000, 64'h0, 1, 0};
        tbl[4] = '{0, 0, 1, 64'h0, 64'h00000000FFFFFFFF,
                   64'h00000000FFFFFFFF, 64'h0, 2, 2};

        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.enc_dec   = 1'b0;
        bus.cbc       = 1'b0;
        bus.iv        = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.start", 64'(core_start), 64'd0);
        chk("rst.err", 64'(err), 64'd0);
        chk("rst.out_data", bus.out_data, 64'd0);
        chk("rst.core_din", core_din, 64'd0);
        chk("rst.blk_cnt", 64'(blk_cnt), 64'd0);
        chk("rst.core_enc", 64'(core_enc), 64'd1);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_block(tbl[i].first, tbl[i].enc, tbl[i].cbc, tbl[i].iv,
                      tbl[i].data, tbl[i].din, tbl[i].res, tbl[i].enc,
                      tbl[i].cnt, tbl[i].rdly, DLY + 2,
                      $sformatf("vec%0d", i));
        end

        // Core never finishes: single err pulse, back to idle
        core_en = 1'b0;
        @(negedge clk);
        drive_in(1'b0, 1'b0, 1'b0, '0, 64'h55);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("tmo.start", 64'(core_start), 64'd1);
        n = 0;
        while (!err && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("tmo.delay", 64'(n), 64'(TO));
        errs = 1;
        seen = 0;
        chk("tmo.idle", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) chk("tmo.rdy", 64'(bus.in_ready), 64'd1);
            if (err) errs++;
            if (bus.out_valid) seen++;
        end
        chk("tmo.pulses", 64'(errs), 64'd1);
        chk("tmo.noout", 64'(seen), 64'd0);
        chk("tmo.cnt", 64'(blk_cnt), 64'd2);
        core_en = 1'b1;

        // Done lands on the last timer cycle: done wins
        core_delay = TO;
        run_block(1'b1, 1'b1, 1'b0, '0, 64'hA5A5_0000_1234_5678,
                  64'hA5A5_0000_1234_5678, 64'h5A5A_FFFF_EDCB_A987,
                  1'b1, 1, 0, TO + 2, "late_done");
        core_delay = DLY;

        // Reset in the middle of WAIT
        @(negedge clk);
        drive_in(1'b1, 1'b0, 1'b1, 64'h1111, 64'h2222);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst.in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst.blk_cnt", 64'(blk_cnt), 64'd0);
        chk("arst.core_enc", 64'(core_enc), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        errs = 0;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (err) errs++;
            if (bus.out_valid) seen++;
        end
        chk("arst.noerr", 64'(errs), 64'd0);
        chk("arst.noout", 64'(seen), 64'd0);
        chk("arst.idle", 64'(bus.in_ready), 64'd1);

        // Non-first block right after reset: enc/ECB, zero chain
        model(1'b0, 1'b0, 1'b1, 64'hFFFF, 64'h0F0F, edin, eout);
        run_block(1'b0, 1'b0, 1'b1, 64'hFFFF, 64'h0F0F, edin, eout,
                  m_enc, m_cnt, 1, DLY + 2, "post_rst");

        // Random messages; long first-free run drives blk_cnt to saturation
        for (int i = 0; i < 40; i++) begin
            first = (i == 0) || (i >= 20 && $urandom_range(3) == 0);
            enc   = 1'($urandom_range(1));
            cbc   = 1'($urandom_range(1));
            ivv   = {$urandom, $urandom};
            data  = {$urandom, $urandom};
            model(first, enc, cbc, ivv, data, edin, eout);
            run_block(first, enc, cbc, ivv, data, edin, eout, m_enc,
                      m_cnt, int'($urandom_range(2)), DLY + 2,
                      $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/des_mode_ctrl.md
Name: des_mode_ctrl

Overview:
- Block-cipher mode controller between the data interface and an iterative DES datapath core; adds ECB/CBC chaining, encrypt/decrypt select and valid/ready streaming.
- Feeds the core via a start/done handshake. The core itself is external and has no chaining state.
- Parametrised in block width and core timeout, so the same controller serves 64-bit DES and wider successors.

Parameters:
BLK_W, 64, block/IV/data width in bits
CNT_W, 16, width of processed-block counter
TIMEOUT, 64, max cycles from core_start to core_done before error; must be >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
enc_dec  input  1  1=encrypt, 0=decrypt; sampled on accept of a block with in_first=1
cbc  input  1  1=CBC, 0=ECB; sampled as enc_dec
iv  input  BLK_W  initialisation vector; sampled as enc_dec
in_valid  input  1  input block valid
in_ready  output  1  controller can accept a block
in_data  input  BLK_W  plaintext (enc) or ciphertext (dec)
in_first  input  1  block starts a new message; reload chain from iv
out_valid  output  1  result block valid
out_ready  input  1  downstream accepts result
out_data  output  BLK_W  result block
core_start  output  1  one-cycle start pulse to core
core_enc  output  1  direction to core, held for message
core_din  output  BLK_W  core input, stable from core_start until core_done
core_dout  input  BLK_W  core result, valid when core_done=1
core_done  input  1  one-cycle core completion pulse
blk_cnt  output  CNT_W  blocks delivered since last in_first accept, saturating
err  output  1  one-cycle pulse on core timeout

Behaviour:
- Reset (rst=0, async): state=IDLE; in_ready=1; out_valid=0; core_start=0; err=0; out_data=0; core_din=0; chain=0; blk_cnt=0; core_enc=1; mode regs cleared to enc/ECB.
- States:
  - IDLE: in_ready=1; all other handshake outputs 0.
    - On in_valid&in_ready: go to START.
    - If in_first=1: latch enc_dec/cbc into mode regs, chain<=iv, blk_cnt<=0.
    - Effective chain for this block is iv when in_first=1, else chain.
    - Encrypt+CBC: core_din<=in_data^effective_chain. Otherwise core_din<=in_data.
    - Decrypt+CBC: save in_data to ct_hold.
  - START: core_start=1 for exactly one cycle, then go to WAIT with timer cleared.
  - WAIT: timer increments each cycle.
    - On core_done: capture result, go to OUT.
      - Encrypt+CBC: out_data<=core_dout, chain<=core_dout.
      - Decrypt+CBC: out_data<=core_dout^chain, chain<=ct_hold.
      - ECB: out_data<=core_dout.
    - On timer==TIMEOUT-1 without core_done: err=1 for one cycle, go to IDLE, chain unchanged, no output.
    - core_done and timeout in the same cycle: core_done wins, no err.
  - OUT: out_valid=1. out_data is held stable until out_ready. On out_ready: blk_cnt++ (saturates at all-ones), go to IDLE.
- Latency:
  - Accept at cycle 0; core_start at cycle 1.
  - With core_done at cycle 1+k: out_valid at cycle 2+k. Earliest next accept is the cycle after the out transfer.
- core_done outside WAIT is ignored. in_valid outside IDLE is not accepted (in_ready=0).
- core_enc equals the latched enc_dec.
- A block with in_first=0 before any in_first block uses chain=0 and the reset mode.
- Reset asserted mid-operation aborts immediately. No out_valid or err is produced for the aborted block.

Test Plan:
- Bench core model: core_dout=core_din ^ {BLK_W{1'b1}}, core_done 16 cycles after core_start.
- ECB encrypt, in_first=1, in_data=64'h0123456789ABCDEF -> core_din=64'h0123456789ABCDEF, out_data=64'hFEDCBA9876543210, out_valid at cycle 18, blk_cnt=1 after transfer.
- CBC encrypt, iv=64'h00000000FFFFFFFF, blocks 0,0 (second with in_first=0) -> core_din FFFF... no: core_din 64'h00000000FFFFFFFF then 64'hFFFFFFFF00000000; out_data 64'hFFFFFFFF00000000 then 64'h00000000FFFFFFFF.
- CBC decrypt, same iv, in_data 64'hFFFFFFFF00000000 then 64'h00000000FFFFFFFF -> out_data 64'h0 then 64'h0; core_enc=0 throughout.
- Backpressure: out_ready held low 5 cycles -> out_valid and out_data stable, in_ready=0; transfer on the 6th cycle, in_ready=1 the next cycle.
- Timeout, TIMEOUT=32, core never asserts done -> err pulses exactly once, 32 cycles after core_start; state returns to IDLE; blk_cnt unchanged. Also drive core_done on the same cycle as timer==31 -> no err, normal output.
- Reset: drive rst=0 during WAIT (cycle 8 of 16) -> in_ready=1, out_valid=0, blk_cnt=0 immediately. A late core_done after release is ignored.
